// File: rtl/accelerator_state_vector_state_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : accelerator_state_pkg
//  Purpose  : Shared types, constants and the fixed-point multiply-truncate
//             helper for the x(k+1) = A*x(k) + B*u(k) engine.
//  Revision : 1.0  initial release
// ============================================================================
package accelerator_state_pkg;

  // Widest data element the arithmetic helper supports.
  localparam int MAX_DATA_SIZE = 64;

  localparam logic [MAX_DATA_SIZE-1:0] ZERO_DATA   = '0;
  localparam logic [63:0]              ONE_CONTROL = 64'd1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    LOAD_U = 3'd2,
    ACC_A  = 3'd3,
    ACC_B  = 3'd4,
    EMIT   = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Full double-width signed product, arithmetic shift right by the number
  // of fractional bits, low MAX_DATA_SIZE bits kept. Callers sign-extend
  // narrower operands to MAX_DATA_SIZE and slice the result back down; the
  // low bits are identical to a native-width computation.
  function automatic logic [MAX_DATA_SIZE-1:0] fx_mul_trunc(
    input logic signed [MAX_DATA_SIZE-1:0] a,
    input logic signed [MAX_DATA_SIZE-1:0] b,
    input int                              frac
  );
    logic signed [2*MAX_DATA_SIZE-1:0] a_w;
    logic signed [2*MAX_DATA_SIZE-1:0] b_w;
    logic signed [2*MAX_DATA_SIZE-1:0] p;
    a_w = {{MAX_DATA_SIZE{a[MAX_DATA_SIZE-1]}}, a};
    b_w = {{MAX_DATA_SIZE{b[MAX_DATA_SIZE-1]}}, b};
    p   = a_w * b_w;
    p   = p >>> frac;
    return p[MAX_DATA_SIZE-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/accelerator_state_vector_state_if.sv
`default_nettype none
// ============================================================================
//  Module   : accelerator_state_vector_state_if
//  Purpose  : Control, operand-stream and result bundle of the state-vector
//             engine. The slave side is the engine, the master the feeder.
//  Revision : 1.0  initial release
// ============================================================================
interface accelerator_state_vector_state_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
);
  logic                    START;
  logic                    READY;
  logic [CONTROL_SIZE-1:0] SIZE_N_IN;
  logic [CONTROL_SIZE-1:0] SIZE_M_IN;
  logic [DATA_SIZE-1:0]    DATA_IN;
  logic                    DATA_IN_ENABLE;
  logic                    DATA_IN_READY;
  logic [DATA_SIZE-1:0]    DATA_OUT;
  logic                    DATA_OUT_ENABLE;
  logic [CONTROL_SIZE-1:0] INDEX_OUT;

  modport master (
    output START, SIZE_N_IN, SIZE_M_IN, DATA_IN, DATA_IN_ENABLE,
    input  READY, DATA_IN_READY, DATA_OUT, DATA_OUT_ENABLE, INDEX_OUT
  );

  modport slave (
    input  START, SIZE_N_IN, SIZE_M_IN, DATA_IN, DATA_IN_ENABLE,
    output READY, DATA_IN_READY, DATA_OUT, DATA_OUT_ENABLE, INDEX_OUT
  );
endinterface
`default_nettype wire

// File: rtl/accelerator_state_vector_state_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : accelerator_state_vector_buffer
//  Purpose  : Register-file vector buffer, one synchronous write port and one
//             combinational read port so a stored element can be paired with
//             the streamed coefficient in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module accelerator_state_vector_buffer #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/accelerator_state_vector_state.sv
`default_nettype none
// ============================================================================
//  Module   : accelerator_state_vector_state
//  Purpose  : Element-serial x(k+1) = A*x(k) + B*u(k). x and u are buffered,
//             then each row of A and B streams through one MAC; one result
//             per row is emitted with its row index. Data width up to 64.
//  Revision : 1.0  initial release
// ============================================================================
module accelerator_state_vector_state
  import accelerator_state_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FRACTION     = 0,
  parameter int N_MAX        = 64,
  parameter int M_MAX        = 64
) (
  input  logic                             CLK,
  input  logic                             RST,
  accelerator_state_vector_state_if.slave  bus
);

  localparam int X_AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int U_AW = (M_MAX > 1) ? $clog2(M_MAX) : 1;
  localparam logic [CONTROL_SIZE-1:0] C_ONE  = ONE_CONTROL[CONTROL_SIZE-1:0];
  localparam logic [CONTROL_SIZE-1:0] C_ZERO = '0;
  localparam logic [DATA_SIZE-1:0]    D_ZERO = ZERO_DATA[DATA_SIZE-1:0];

  state_t                   state;
  state_t                   next_state;
  logic [CONTROL_SIZE-1:0]  size_n;
  logic [CONTROL_SIZE-1:0]  size_m;
  logic [CONTROL_SIZE-1:0]  col;
  logic [CONTROL_SIZE-1:0]  row;
  logic [DATA_SIZE-1:0]     acc;

  logic                     in_ready;
  logic                     accept;
  logic                     col_last_n;
  logic                     col_last_m;
  logic                     phase_last;
  logic                     row_last;
  logic                     m_is_zero;
  logic                     size_bad;
  logic                     x_wr_en;
  logic                     u_wr_en;
  logic [DATA_SIZE-1:0]     x_rd;
  logic [DATA_SIZE-1:0]     u_rd;
  logic signed [DATA_SIZE-1:0] coef_s;
  logic signed [DATA_SIZE-1:0] operand_s;
  logic [MAX_DATA_SIZE-1:0] product_full;
  logic [DATA_SIZE-1:0]     product;

  // Handshake and phase-boundary decode.
  assign in_ready   = (state == LOAD_X) || (state == LOAD_U) ||
                      (state == ACC_A)  || (state == ACC_B);
  assign accept     = in_ready && bus.DATA_IN_ENABLE;
  assign col_last_n = (col == size_n - C_ONE);
  assign col_last_m = (col == size_m - C_ONE);
  assign phase_last = ((state == LOAD_X) || (state == ACC_A)) ? col_last_n : col_last_m;
  assign row_last   = (row == size_n - C_ONE);
  assign m_is_zero  = (size_m == C_ZERO);
  assign size_bad   = (bus.SIZE_N_IN == C_ZERO) ||
                      (bus.SIZE_N_IN > CONTROL_SIZE'(N_MAX)) ||
                      (bus.SIZE_M_IN > CONTROL_SIZE'(M_MAX));

  assign bus.DATA_IN_READY = in_ready;

  assign x_wr_en = accept && (state == LOAD_X);
  assign u_wr_en = accept && (state == LOAD_U);

  accelerator_state_vector_buffer #(
    .DEPTH (N_MAX),
    .WIDTH (DATA_SIZE),
    .ADDR_W(X_AW)
  ) u_x_buf (
    .clk    (CLK),
    .wr_en  (x_wr_en),
    .wr_addr(col[X_AW-1:0]),
    .wr_data(bus.DATA_IN),
    .rd_addr(col[X_AW-1:0]),
    .rd_data(x_rd)
  );

  accelerator_state_vector_buffer #(
    .DEPTH (M_MAX),
    .WIDTH (DATA_SIZE),
    .ADDR_W(U_AW)
  ) u_u_buf (
    .clk    (CLK),
    .wr_en  (u_wr_en),
    .wr_addr(col[U_AW-1:0]),
    .wr_data(bus.DATA_IN),
    .rd_addr(col[U_AW-1:0]),
    .rd_data(u_rd)
  );

  // The column counter addresses x during the A phase and u during the B phase.
  assign coef_s       = bus.DATA_IN;
  assign operand_s    = (state == ACC_B) ? u_rd : x_rd;
  assign product_full = fx_mul_trunc(MAX_DATA_SIZE'(coef_s), MAX_DATA_SIZE'(operand_s), FRACTION);
  assign product      = product_full[DATA_SIZE-1:0];

  // State register; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (bus.START) next_state = size_bad ? DONE : LOAD_X;
      LOAD_X: if (accept && col_last_n) next_state = m_is_zero ? ACC_A : LOAD_U;
      LOAD_U: if (accept && col_last_m) next_state = ACC_A;
      ACC_A:  if (accept && col_last_n) next_state = m_is_zero ? EMIT : ACC_B;
      ACC_B:  if (accept && col_last_m) next_state = EMIT;
      EMIT:   next_state = row_last ? DONE : ACC_A;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Sizes, counters, accumulator and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      size_n              <= C_ZERO;
      size_m              <= C_ZERO;
      col                 <= C_ZERO;
      row                 <= C_ZERO;
      acc                 <= D_ZERO;
      bus.DATA_OUT        <= D_ZERO;
      bus.INDEX_OUT       <= C_ZERO;
      bus.DATA_OUT_ENABLE <= 1'b0;
      bus.READY           <= 1'b0;
    end else begin
      bus.DATA_OUT_ENABLE <= 1'b0;
      bus.READY           <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.START) begin
            size_n <= bus.SIZE_N_IN;
            size_m <= bus.SIZE_M_IN;
            col    <= C_ZERO;
            row    <= C_ZERO;
            acc    <= D_ZERO;
          end
        end
        LOAD_X, LOAD_U: begin
          if (accept) begin
            col <= phase_last ? C_ZERO : col + C_ONE;
          end
        end
        ACC_A, ACC_B: begin
          if (accept) begin
            acc <= acc + product;
            col <= phase_last ? C_ZERO : col + C_ONE;
          end
        end
        EMIT: begin
          bus.DATA_OUT        <= acc;
          bus.INDEX_OUT       <= row;
          bus.DATA_OUT_ENABLE <= 1'b1;
          acc                 <= D_ZERO;
          row                 <= row + C_ONE;
          col                 <= C_ZERO;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accelerator_state_vector_state.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accelerator_state_vector_state
//  Purpose  : Scoreboard bench for the state-vector engine. Three instances:
//             Q0 64-bit, Q8 64-bit and 8-bit wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_accelerator_state_vector_state;

  typedef struct {
    int          dut;
    bit          is_ready;
    logic [63:0] data;
    logic [63:0] idx;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start [3];
  logic [63:0] size_n [3];
  logic [63:0] size_m [3];
  logic [63:0] din [3];
  logic        en [3];
  logic        inrdy [3];
  logic        oe [3];
  logic        rdy [3];
  logic [63:0] dout [3];
  logic [63:0] idx [3];

  exp_t        exp_q[$];
  logic [63:0] stream_q[$];
  int          n_cmp;
  int          n_bad;

  accelerator_state_vector_state_if #(.DATA_SIZE(64), .CONTROL_SIZE(64)) if0 ();
  accelerator_state_vector_state_if #(.DATA_SIZE(64), .CONTROL_SIZE(64)) if1 ();
  accelerator_state_vector_state_if #(.DATA_SIZE(8),  .CONTROL_SIZE(64)) if2 ();

  accelerator_state_vector_state #(.DATA_SIZE(64), .CONTROL_SIZE(64), .FRACTION(0), .N_MAX(4), .M_MAX(4))
    dut0 (.CLK(clk), .RST(rst_n), .bus(if0));
  accelerator_state_vector_state #(.DATA_SIZE(64), .CONTROL_SIZE(64), .FRACTION(8), .N_MAX(4), .M_MAX(4))
    dut1 (.CLK(clk), .RST(rst_n), .bus(if1));
  accelerator_state_vector_state #(.DATA_SIZE(8), .CONTROL_SIZE(64), .FRACTION(0), .N_MAX(4), .M_MAX(4))
    dut2 (.CLK(clk), .RST(rst_n), .bus(if2));

  assign if0.START = start[0];  assign if0.SIZE_N_IN = size_n[0];  assign if0.SIZE_M_IN = size_m[0];
  assign if0.DATA_IN = din[0];  assign if0.DATA_IN_ENABLE = en[0];
  assign if1.START = start[1];  assign if1.SIZE_N_IN = size_n[1];  assign if1.SIZE_M_IN = size_m[1];
  assign if1.DATA_IN = din[1];  assign if1.DATA_IN_ENABLE = en[1];
  assign if2.START = start[2];  assign if2.SIZE_N_IN = size_n[2];  assign if2.SIZE_M_IN = size_m[2];
  assign if2.DATA_IN = din[2][7:0];  assign if2.DATA_IN_ENABLE = en[2];

  assign inrdy[0] = if0.DATA_IN_READY;  assign oe[0] = if0.DATA_OUT_ENABLE;  assign rdy[0] = if0.READY;
  assign inrdy[1] = if1.DATA_IN_READY;  assign oe[1] = if1.DATA_OUT_ENABLE;  assign rdy[1] = if1.READY;
  assign inrdy[2] = if2.DATA_IN_READY;  assign oe[2] = if2.DATA_OUT_ENABLE;  assign rdy[2] = if2.READY;
  assign dout[0] = if0.DATA_OUT;  assign idx[0] = if0.INDEX_OUT;
  assign dout[1] = if1.DATA_OUT;  assign idx[1] = if1.INDEX_OUT;
  assign dout[2] = {56'd0, if2.DATA_OUT};  assign idx[2] = if2.INDEX_OUT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_out(input int d, input logic [63:0] data, input logic [63:0] index);
    exp_t e;
    e.dut = d; e.is_ready = 1'b0; e.data = data; e.idx = index;
    exp_q.push_back(e);
  endtask

  task automatic push_rdy(input int d);
    exp_t e;
    e.dut = d; e.is_ready = 1'b1; e.data = '0; e.idx = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: pop one expectation per DUT output event and compare.
  task automatic check_event(input int d, input bit is_rdy);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_unexpected: got dut%0d %s event, expected none", d, is_rdy ? "ready" : "output");
    end else begin
      e = exp_q.pop_front();
      chk("sb_dut", 64'(d), 64'(e.dut));
      chk("sb_kind", 64'(is_rdy), 64'(e.is_ready));
      if (!is_rdy && !e.is_ready) begin
        chk("sb_data", dout[d], e.data);
        chk("sb_index", idx[d], e.idx);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (oe[d] === 1'b1)  check_event(d, 1'b0);
      if (rdy[d] === 1'b1) check_event(d, 1'b1);
    end
  end

  task automatic pulse_start(input int d, input logic [63:0] n, input logic [63:0] m);
    size_n[d] = n;
    size_m[d] = m;
    start[d]  = 1'b1;
    @(posedge clk); #1;
    start[d]  = 1'b0;
  endtask

  // Feeds stream_q; with gap set, DATA_IN_ENABLE idles one cycle between elements.
  task automatic send_stream(input int d, input bit gap);
    int t;
    for (int k = 0; k < stream_q.size(); k++) begin
      din[d] = stream_q[k];
      en[d]  = 1'b1;
      t = 0;
      while (inrdy[d] !== 1'b1 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL handshake_timeout: got DATA_IN_READY=0 for 50 cycles, expected 1");
      end
      @(posedge clk); #1;
      en[d] = 1'b0;
      if (gap && k < stream_q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Called right after the last element is accepted: result one cycle later, READY one after that.
  task automatic check_tail(input int d);
    chk("tail_no_early_out", 64'(oe[d]), 64'd0);
    @(posedge clk); #1;
    chk("tail_out_pulse", 64'(oe[d]), 64'd1);
    chk("tail_no_early_ready", 64'(rdy[d]), 64'd0);
    @(posedge clk); #1;
    chk("tail_ready_pulse", 64'(rdy[d]), 64'd1);
    chk("tail_out_single", 64'(oe[d]), 64'd0);
  endtask

  task automatic run_case1(input bit gap);
    push_out(0, 64'd20, 64'd0);
    push_out(0, 64'd29, 64'd1);
    push_rdy(0);
    pulse_start(0, 64'd2, 64'd1);
    stream_q = '{64'd1, 64'd2, 64'd3, 64'd1, 64'd2, 64'd5, 64'd3, 64'd4, 64'd6};
    send_stream(0, gap);
    check_tail(0);
  endtask

  task automatic run_invalid(input logic [63:0] n, input logic [63:0] m);
    push_rdy(0);
    pulse_start(0, n, m);
    chk("inv_ready_not_yet", 64'(rdy[0]), 64'd0);
    chk("inv_in_ready_c1", 64'(inrdy[0]), 64'd0);
    @(posedge clk); #1;
    chk("inv_ready", 64'(rdy[0]), 64'd1);
    chk("inv_in_ready_c2", 64'(inrdy[0]), 64'd0);
    chk("inv_no_out", 64'(oe[0]), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0; size_n[d] = '0; size_m[d] = '0; din[d] = '0; en[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_data_out", dout[0], 64'd0);
    chk("rst_index_out", idx[0], 64'd0);
    chk("rst_out_en", 64'(oe[0]), 64'd0);
    chk("rst_ready", 64'(rdy[0]), 64'd0);
    chk("rst_in_ready", 64'(inrdy[0]), 64'd0);

    // Basic case, continuous and gapped feed
    run_case1(1'b0);
    repeat (2) @(posedge clk); #1;
    chk("hold_data_out", dout[0], 64'd29);
    chk("hold_index_out", idx[0], 64'd1);
    run_case1(1'b1);

    // Signed operands: -3*4 + 2*(-5) = -22
    push_out(0, 64'hFFFF_FFFF_FFFF_FFEA, 64'd0);
    push_rdy(0);
    pulse_start(0, 64'd1, 64'd1);
    stream_q = '{-64'sd3, 64'd2, 64'd4, -64'sd5};
    send_stream(0, 1'b0);
    check_tail(0);

    // Q8: 2.0 * 1.5 = 3.0, M=0 skips the B phase
    push_out(1, 64'h300, 64'd0);
    push_rdy(1);
    pulse_start(1, 64'd1, 64'd0);
    stream_q = '{64'h200, 64'h180};
    send_stream(1, 1'b0);
    check_tail(1);

    // Q8: 2.0 * -1.5 = -3.0
    push_out(1, 64'hFFFF_FFFF_FFFF_FD00, 64'd0);
    push_rdy(1);
    pulse_start(1, 64'd1, 64'd0);
    stream_q = '{64'h200, -64'sh180};
    send_stream(1, 1'b0);
    check_tail(1);

    // Invalid sizes: N=0, N=N_MAX+1, M=M_MAX+1
    run_invalid(64'd0, 64'd1);
    run_invalid(64'd5, 64'd1);
    run_invalid(64'd1, 64'd5);

    // 8-bit wrap: 100*2 + 1*0 = 200 -> 0xC8
    push_out(2, 64'hC8, 64'd0);
    push_rdy(2);
    pulse_start(2, 64'd1, 64'd1);
    stream_q = '{64'd100, 64'd1, 64'd2, 64'd0};
    send_stream(2, 1'b0);
    check_tail(2);

    // Abort in ACC_A of row 0, then a clean rerun
    pulse_start(0, 64'd2, 64'd1);
    stream_q = '{64'd1, 64'd2, 64'd3, 64'd1};
    send_stream(0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("abort_out_en", 64'(oe[0]), 64'd0);
    chk("abort_in_ready", 64'(inrdy[0]), 64'd0);
    chk("abort_data_out", dout[0], 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("abort_quiet", 64'(oe[0] | rdy[0]), 64'd0);
    run_case1(1'b0);

    repeat (10) @(posedge clk); #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accelerator_state_vector_state.md
Name: accelerator_state_vector_state

Overview:
- Computes the next-state vector of the discrete state-space model: x(k+1) = A·x(k) + B·u(k).
- Sits directly upstream of accelerator_state_feedback, which consumes the x(k+1) elements this block emits.
- All operands arrive as a single element-serial stream with a valid/ready handshake.
- One fixed-point multiply-accumulate datapath; results come out row by row.

Parameters:
- DATA_SIZE, 64: width of every data element; two's-complement fixed point.
- CONTROL_SIZE, 64: width of size/index fields.
- FRACTION, 0: number of fractional bits in the Q format.
- N_MAX, 64: maximum state dimension; sets the depth of the x buffer.
- M_MAX, 64: maximum input dimension; sets the depth of the u buffer.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- START  in  1  single-cycle pulse that begins an operation; sampled only in IDLE
- READY  out  1  single-cycle pulse when the operation completes
- SIZE_N_IN  in  CONTROL_SIZE  state dimension N; sampled on START
- SIZE_M_IN  in  CONTROL_SIZE  input dimension M; sampled on START
- DATA_IN  in  DATA_SIZE  operand element
- DATA_IN_ENABLE  in  1  element valid
- DATA_IN_READY  out  1  block can accept an element
- DATA_OUT  out  DATA_SIZE  element x(k+1)(i)
- DATA_OUT_ENABLE  out  1  single-cycle pulse; DATA_OUT is valid
- INDEX_OUT  out  CONTROL_SIZE  row index i of DATA_OUT

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; counters and accumulator cleared. Buffer contents are don't-care.
- Reset mid-operation: the operation aborts immediately. No READY pulse and no partial output follow.
- Handshake: an element transfers on any cycle where DATA_IN_ENABLE=1 and DATA_IN_READY=1. Elements presented while DATA_IN_READY=0 are not consumed.
- Stream order:
  - x(0..N-1)
  - u(0..M-1)
  - then, for each row i in 0..N-1: A(i,0..N-1) followed by B(i,0..M-1).
- FSM states:
  - IDLE: DATA_IN_READY=0. On START, latch N and M. If N=0, N>N_MAX, or M>M_MAX, go to DONE. Otherwise go to LOAD_X.
  - LOAD_X: store x(j) in buffer; j counts up. After j=N-1 is accepted, go to LOAD_U, or to ACC_A if M=0.
  - LOAD_U: store u(m). After m=M-1 is accepted, go to ACC_A.
  - ACC_A: on each accepted element, acc += trunc(A(i,j)·x(j)). After j=N-1, go to ACC_B, or to EMIT if M=0.
  - ACC_B: acc += trunc(B(i,m)·u(m)). After m=M-1, go to EMIT.
  - EMIT: one cycle with DATA_IN_READY=0. DATA_OUT=acc, INDEX_OUT=i, DATA_OUT_ENABLE=1; acc is cleared. If i=N-1 go to DONE; otherwise i++ and go to ACC_A.
  - DONE: READY=1 for one cycle, then IDLE.
- DATA_IN_READY is 1 in LOAD_X, LOAD_U, ACC_A and ACC_B; 0 elsewhere.
- Arithmetic:
  - Full 2·DATA_SIZE signed product, arithmetic shift right by FRACTION, keep the low DATA_SIZE bits.
  - Accumulator is DATA_SIZE wide and wraps modulo 2^DATA_SIZE. No saturation.
- Latency:
  - The DATA_OUT_ENABLE pulse for row i is registered one cycle after the last B(i,·) element is accepted, or the last A(i,·) element when M=0.
  - READY follows the last DATA_OUT_ENABLE by one cycle.
- Throughput: 1 element/cycle when fed continuously, plus 1 bubble per row for EMIT.
- DATA_OUT and INDEX_OUT hold their values between pulses.
- START outside IDLE is ignored.
- An invalid size gives READY two cycles after START, with no DATA_OUT_ENABLE pulse.

Decomposition:
- Package accelerator_state_pkg holds:
  - FSM state enum (IDLE, LOAD_X, LOAD_U, ACC_A, ACC_B, EMIT, DONE)
  - the fixed-point multiply-truncate function
  - ZERO_DATA and ONE_CONTROL constants.
- One natural sub-module: accelerator_state_vector_buffer, a parameterised register-file vector buffer (depth, width; one write port, one read port). It is instantiated twice, for x and for u.

Test Plan:
- FRACTION=0, N=2, M=1; x=[1,2], u=[3], A=[[1,2],[3,4]], B=[[5],[6]] -> DATA_OUT 20 with INDEX_OUT 0, then 29 with INDEX_OUT 1, then READY.
- Same operands with DATA_IN_ENABLE dropped every other cycle -> same results; no element is lost or duplicated.
- FRACTION=8, N=1, M=0; x=[0x200] (2.0), A=[[0x180]] (1.5) -> DATA_OUT 0x300; B phase is skipped.
- N=0 or N=N_MAX+1 on START -> no DATA_OUT_ENABLE pulse; READY two cycles later; DATA_IN_READY stays 0.
- RST asserted low during ACC_A of row 0, then released and a fresh START issued with case 1 -> no output from the aborted run; new results 20 and 29.
- Wrap check with DATA_SIZE=8, FRACTION=0, N=1, M=1; x=[100], A=[[2]], u=[1], B=[[0]] -> DATA_OUT 0xC8 (200 mod 256, read as -56).
